// File: rtl/fma_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fma_pkg
//  Purpose : Shared format constants and derived-width helpers for the
//            pipelined FMA add stage.
//  Contents: SP_MW / DP_MW  - mantissa widths (hidden bit included)
//            pw_of()        - product width      (2*MW)
//            hw_of()        - addend high width  (MW+2)
//            rw_of()        - result width       (3*MW+3)
//  Revision: 1.0 - initial release
// ============================================================================
package fma_pkg;

    localparam int SP_MW = 24;
    localparam int DP_MW = 53;

    function automatic int pw_of(input int mw);
        return 2 * mw;
    endfunction

    function automatic int hw_of(input int mw);
        return mw + 2;
    endfunction

    // {high[HW-1:0], mid[PW-1:0], sticky}
    function automatic int rw_of(input int mw);
        return 3 * mw + 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fma_sticky_compen.sv
`default_nettype none
// ============================================================================
//  Module  : fma_sticky_compen
//  Purpose : Low-part handling of the aligned addend. Produces the sticky bit
//            and the compensation carry needed when the addend was
//            one's-complemented for an effective subtraction.
//  Ports   : inv_mask        in  1   effective subtraction
//            c_frac_align_l  in  MW  aligned addend, low part
//            compen          out 1   +1 to inject into the CSA
//            st1             out 1   sticky bit of the low part
//  Revision: 1.0 - initial release
// ============================================================================
module fma_sticky_compen
    import fma_pkg::*;
#(
    parameter int MW = SP_MW
) (
    input  logic          inv_mask,
    input  logic [MW-1:0] c_frac_align_l,
    output logic          compen,
    output logic          st1
);

    logic w_all_ones;
    logic w_any_set;

    assign w_all_ones = &c_frac_align_l;
    assign w_any_set  = |c_frac_align_l;

    // For a subtraction the low part holds ~L. If ~L is all ones then L was
    // zero, so the two's-complement +1 ripples out of the low part into the
    // middle part (compen) and nothing is lost below (sticky clear).
    // Otherwise the +1 is absorbed in the low part and L was non-zero.
    assign compen = inv_mask & w_all_ones;
    assign st1    = inv_mask ? ~w_all_ones : w_any_set;

endmodule
`default_nettype wire

// File: rtl/fma_add_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module  : fma_add_stage_pipe
//  Purpose : Two-stage pipelined FMA add stage. Merges the aligned addend with
//            the carry-save product and emits a sign-magnitude intermediate
//            fraction with sticky LSB and a zero flag. Valid/ready
//            back-pressure, synchronous flush and a pass-through tag.
//  Ports   : clk, rst (sync, active high), flush (sync pipeline kill)
//            in_valid / in_ready / in_tag          - input handshake
//            c_frac_align_h/m/l                    - aligned addend (HW/PW/MW)
//            carry, sum                            - product CSA vectors (PW)
//            inv_mask                              - effective subtraction
//            out_valid / out_ready / out_tag       - output handshake
//            frac_inter_h_s                        - result sign
//            frac_inter                            - magnitude (RW)
//            frac_zero                             - frac_inter == 0
//  Revision: 1.0 - initial release
// ============================================================================
module fma_add_stage_pipe
    import fma_pkg::*;
#(
    parameter int MW = SP_MW,
    parameter int TW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TW-1:0]          in_tag,
    input  logic [hw_of(MW)-1:0]   c_frac_align_h,
    input  logic [pw_of(MW)-1:0]   c_frac_align_m,
    input  logic [MW-1:0]          c_frac_align_l,
    input  logic [pw_of(MW)-1:0]   carry,
    input  logic [pw_of(MW)-1:0]   sum,
    input  logic                   inv_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TW-1:0]          out_tag,
    output logic                   frac_inter_h_s,
    output logic [rw_of(MW)-1:0]   frac_inter,
    output logic                   frac_zero
);

    localparam int PW = pw_of(MW);
    localparam int HW = hw_of(MW);
    localparam int RW = rw_of(MW);

    // ------------------------------------------------------------------
    // Handshake. in_ready is combinational from out_ready so a full
    // pipeline draining one result can accept a new operation in the
    // same cycle (no bubble).
    // ------------------------------------------------------------------
    logic w_s2_adv;
    logic w_s1_adv;
    logic r_s1_valid;
    logic r_out_valid;

    assign w_s2_adv = ~r_out_valid | out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign in_ready = w_s1_adv;

    // ------------------------------------------------------------------
    // Stage 1: low-part compensation/sticky and 3:2 CSA.
    // ------------------------------------------------------------------
    logic          w_compen;
    logic          w_st1;
    logic [PW-1:0] w_csa_sum;
    logic [PW-1:0] w_csa_maj;
    logic [PW-1:0] w_csa_carry;
    logic          w_csa_co;

    fma_sticky_compen #(
        .MW             (MW)
    ) u_sticky_compen (
        .inv_mask       (inv_mask),
        .c_frac_align_l (c_frac_align_l),
        .compen         (w_compen),
        .st1            (w_st1)
    );

    assign w_csa_sum = c_frac_align_m ^ carry ^ sum;
    assign w_csa_maj = (c_frac_align_m & carry) |
                       (c_frac_align_m & sum)   |
                       (carry & sum);
    // The shifted carry vector has a free slot at bit 0; the low-part
    // compensation +1 rides in there at no extra adder cost.
    assign w_csa_carry = {w_csa_maj[PW-2:0], w_compen};
    assign w_csa_co    = w_csa_maj[PW-1];

    logic [PW-1:0] r_s1_carry1;
    logic [PW-1:0] r_s1_sum1;
    logic          r_s1_csa_co;
    logic          r_s1_st1;
    logic [HW:0]   r_s1_high;      // {inv_mask, c_frac_align_h}
    logic [TW-1:0] r_s1_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1_adv && in_valid) begin
            r_s1_carry1 <= w_csa_carry;
            r_s1_sum1   <= w_csa_sum;
            r_s1_csa_co <= w_csa_co;
            r_s1_st1    <= w_st1;
            r_s1_high   <= {inv_mask, c_frac_align_h};
            r_s1_tag    <= in_tag;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: carry-propagate add, high-part increment, magnitude fix.
    // ------------------------------------------------------------------
    logic [PW:0]   w_cla;
    logic          w_inc;
    logic [HW:0]   w_h;
    logic [RW-1:0] w_tmp;
    logic          w_sign;
    logic [RW-1:0] w_frac;
    logic          w_zero;

    assign w_cla  = {1'b0, r_s1_carry1} + {1'b0, r_s1_sum1};
    // At most one of the two carries can be set for a well-formed product,
    // so OR-ing them is a single +1 into the high part.
    assign w_inc  = r_s1_csa_co | w_cla[PW];
    // Wraps modulo 2^(HW+1); for exact cancellation this lands on zero.
    assign w_h    = r_s1_high + {{HW{1'b0}}, w_inc};
    assign w_tmp  = {w_h[HW-1:0], w_cla[PW-1:0], r_s1_st1};
    assign w_sign = w_h[HW];
    assign w_frac = w_sign ? (~w_tmp + RW'(1)) : w_tmp;
    assign w_zero = ~|w_frac;

    logic [TW-1:0] r_out_tag;
    logic          r_out_sign;
    logic [RW-1:0] r_out_frac;
    logic          r_out_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_out_sign  <= 1'b0;
            r_out_frac  <= '0;
            r_out_zero  <= 1'b0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
            end
            // Data only moves with a valid operation so results hold
            // steady while the consumer stalls.
            if (!flush && w_s2_adv && r_s1_valid) begin
                r_out_tag  <= r_s1_tag;
                r_out_sign <= w_sign;
                r_out_frac <= w_frac;
                r_out_zero <= w_zero;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_tag        = r_out_tag;
    assign frac_inter_h_s = r_out_sign;
    assign frac_inter     = r_out_frac;
    assign frac_zero      = r_out_zero;

endmodule
`default_nettype wire

// File: tb/tb_fma_add_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module  : tb_fma_add_stage_pipe
//  Purpose : Directed self-checking bench for fma_add_stage_pipe (MW=24, TW=8).
//  Revision: 1.0 - initial release
// ============================================================================
module tb_fma_add_stage_pipe;

    localparam int MW = 24;
    localparam int TW = 8;
    localparam int PW = 48;
    localparam int HW = 26;
    localparam int RW = 75;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] in_tag;
    logic [HW-1:0] c_frac_align_h;
    logic [PW-1:0] c_frac_align_m;
    logic [MW-1:0] c_frac_align_l;
    logic [PW-1:0] carry;
    logic [PW-1:0] sum;
    logic          inv_mask;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_tag;
    logic          frac_inter_h_s;
    logic [RW-1:0] frac_inter;
    logic          frac_zero;

    int n_checks = 0;
    int n_pass   = 0;

    fma_add_stage_pipe #(
        .MW             (MW),
        .TW             (TW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_tag         (in_tag),
        .c_frac_align_h (c_frac_align_h),
        .c_frac_align_m (c_frac_align_m),
        .c_frac_align_l (c_frac_align_l),
        .carry          (carry),
        .sum            (sum),
        .inv_mask       (inv_mask),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_tag        (out_tag),
        .frac_inter_h_s (frac_inter_h_s),
        .frac_inter     (frac_inter),
        .frac_zero      (frac_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    endtask

    task automatic drive(input logic [HW-1:0] h, input logic [PW-1:0] m, input logic [MW-1:0] l,
                         input logic [PW-1:0] cy, input logic [PW-1:0] sm, input logic inv,
                         input logic [TW-1:0] tg);
        c_frac_align_h = h;
        c_frac_align_m = m;
        c_frac_align_l = l;
        carry          = cy;
        sum            = sm;
        inv_mask       = inv;
        in_tag         = tg;
    endtask

    // One operation through an otherwise empty pipeline, out_ready high.
    task automatic run_single(input string nm,
                              input logic [HW-1:0] h, input logic [PW-1:0] m, input logic [MW-1:0] l,
                              input logic [PW-1:0] cy, input logic [PW-1:0] sm, input logic inv,
                              input logic [TW-1:0] tg,
                              input logic [RW-1:0] ef, input logic es, input logic ez);
        drive(h, m, l, cy, sm, inv, tg);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({nm, "_valid_lat1"}, 128'(out_valid), 128'(1'b0));
        tick();
        check({nm, "_valid"}, 128'(out_valid), 128'(1'b1));
        check({nm, "_frac"},  128'(frac_inter), 128'(ef));
        check({nm, "_sign"},  128'(frac_inter_h_s), 128'(es));
        check({nm, "_zero"},  128'(frac_zero), 128'(ez));
        check({nm, "_tag"},   128'(out_tag), 128'(tg));
        tick();
        check({nm, "_drained"}, 128'(out_valid), 128'(1'b0));
    endtask

    initial begin : main
        logic [RW-1:0] e_frac;
        logic [TW-1:0] e_tag;
        int  sent;
        int  got;
        int  stall_left;
        bit  saw_stall;
        bit  accepted;

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive('0, '0, '0, '0, '0, 1'b0, '0);
        tick();
        tick();
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_out_tag",   128'(out_tag), 128'(0));
        check("rst_sign",      128'(frac_inter_h_s), 128'(1'b0));
        check("rst_frac",      128'(frac_inter), 128'(0));
        check("rst_zero",      128'(frac_zero), 128'(1'b0));
        rst = 1'b0;
        tick();
        check("idle_in_ready", 128'(in_ready), 128'(1'b1));

        // 1 + 2 in the middle part, shifted up by the sticky slot
        run_single("plain", 26'h0, 48'h1, 24'h0, 48'h0, 48'h2, 1'b0, 8'h5A,
                   75'h6, 1'b0, 1'b0);
        // ~A + A + 1 wraps to zero
        run_single("cancel", 26'h3FFFFFF, 48'hFFFF_FFFF_FFFF, 24'hFFFFFF, 48'h0, 48'h0, 1'b1, 8'hC3,
                   75'h0, 1'b0, 1'b1);
        run_single("negative", 26'h3FFFFFF, 48'hFFFF_FFFF_FFFE, 24'hFFFFFF, 48'h0, 48'h0, 1'b1, 8'h77,
                   75'h2, 1'b1, 1'b0);
        run_single("sticky_add", 26'h0, 48'h0, 24'h000100, 48'h0, 48'h0, 1'b0, 8'h01,
                   75'h1, 1'b0, 1'b0);
        run_single("sticky_sub", 26'h3FFFFFF, 48'hFFFF_FFFF_FFFF, 24'hFFFEFF, 48'h0, 48'h0, 1'b1, 8'h02,
                   75'h1, 1'b1, 1'b0);
        // carry-out of the CSA majority at bit 47 increments the high part
        run_single("csa_co", 26'h0, 48'h8000_0000_0000, 24'h0, 48'h0, 48'h8000_0000_0000, 1'b0, 8'h03,
                   75'h2_0000_0000_0000, 1'b0, 1'b0);
        // carry-out of the 48-bit adder increments the high part (5 -> 6)
        run_single("cla_co", 26'h5, 48'hFFFF_FFFF_FFFF, 24'h0, 48'h0, 48'h1, 1'b0, 8'h04,
                   75'hC_0000_0000_0000, 1'b0, 1'b0);
        // all-ones addend, add, inc=1: high part wraps into the sign bit
        run_single("wrap", 26'h3FFFFFF, 48'hFFFF_FFFF_FFFF, 24'h0, 48'h0, 48'h1, 1'b0, 8'h05,
                   75'h0, 1'b1, 1'b1);

        // Back-pressure: four ops, out_ready low for 3 cycles after first result
        sent       = 0;
        got        = 0;
        stall_left = -1;
        saw_stall  = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (out_valid && stall_left < 0) stall_left = 3;
            out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
            if (stall_left > 0) stall_left--;
            in_valid = (sent < 4);
            drive(26'h0, 48'(sent + 1), 24'h0, 48'h0, 48'h0, 1'b0, 8'(8'h10 + sent));
            #1;
            e_frac = 75'(2 * (got + 1));
            e_tag  = 8'(8'h10 + got);
            if (in_valid && !in_ready) saw_stall = 1'b1;
            if (out_valid && !out_ready)
                check("bp_hold_frac", 128'(frac_inter), 128'(e_frac));
            if (out_valid && out_ready) begin
                check("bp_frac", 128'(frac_inter), 128'(e_frac));
                check("bp_tag",  128'(out_tag), 128'(e_tag));
                got++;
            end
            accepted = in_valid && in_ready;
            tick();
            if (accepted) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", 128'(got), 128'(4));
        check("bp_in_ready_dropped", 128'(saw_stall), 128'(1'b1));
        tick();
        check("bp_no_dup", 128'(out_valid), 128'(1'b0));

        // Flush with two ops in flight
        out_ready = 1'b0;
        drive(26'h0, 48'h5, 24'h0, 48'h0, 48'h0, 1'b0, 8'h21);
        in_valid = 1'b1;
        tick();
        drive(26'h0, 48'h6, 24'h0, 48'h0, 48'h0, 1'b0, 8'h22);
        tick();
        in_valid = 1'b0;
        check("fl_full_valid", 128'(out_valid), 128'(1'b1));
        check("fl_full_in_ready", 128'(in_ready), 128'(1'b0));
        flush = 1'b1;
        drive(26'h0, 48'h7, 24'h0, 48'h0, 48'h0, 1'b0, 8'h23);
        in_valid = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 128'(out_valid), 128'(1'b0));
        check("fl_in_ready", 128'(in_ready), 128'(1'b1));
        out_ready = 1'b1;
        tick();
        check("fl_lost1", 128'(out_valid), 128'(1'b0));
        tick();
        check("fl_lost2", 128'(out_valid), 128'(1'b0));

        // Reset mid-stream
        drive(26'h0, 48'h7, 24'h0, 48'h0, 48'h0, 1'b0, 8'h31);
        in_valid = 1'b1;
        tick();
        drive(26'h0, 48'h8, 24'h0, 48'h0, 48'h0, 1'b0, 8'h32);
        tick();
        check("mr_pre_valid", 128'(out_valid), 128'(1'b1));
        check("mr_pre_frac", 128'(frac_inter), 128'(75'hE));
        rst = 1'b1;
        drive(26'h0, 48'h9, 24'h0, 48'h0, 48'h0, 1'b0, 8'h33);
        tick();
        check("mr_out_valid", 128'(out_valid), 128'(1'b0));
        check("mr_out_tag",   128'(out_tag), 128'(0));
        check("mr_sign",      128'(frac_inter_h_s), 128'(1'b0));
        check("mr_frac",      128'(frac_inter), 128'(0));
        check("mr_zero",      128'(frac_zero), 128'(1'b0));
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check("mr_lost1", 128'(out_valid), 128'(1'b0));
        tick();
        check("mr_lost2", 128'(out_valid), 128'(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
